vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Parametrised multi-mode VGA test-pattern source that drives the 24-bit pixel `data` input of the `vga_ctrl` raster controller. Generalises the fixed seven-bar colour pattern to:
- selectable pattern modes,
- configurable bar and cell sizes,
- frame-synchronous mode switching,
- an optional per-frame horizontal scroll.

It sits between the raster counters (`h_addr`, `v_addr`, `valid`, `vsync` from `vga_ctrl`) and `vga_ctrl`'s colour input, on the 25 MHz pixel clock.

## Interface
Parameters:
- `BAR_LOG2`, 6 — log2 of bar width/height in pixels (bars of 64 px).
- `CELL_LOG2`, 5 — log2 of checkerboard cell size (32 px).
- `SCROLL_STEP`, 4 — pixels added to scroll offset per frame (1..255).
- `FCNT_W`, 16 — frame counter width.

Ports:
- `clk` input 1 — pixel clock. One clock domain. Reset is asynchronous and active-low.
- `reset` input 1 — asynchronous, active-low reset.
- `h_addr` input 10 — current pixel column.
- `v_addr` input 10 — current pixel row.
- `valid` input 1 — active-video qualifier for `h_addr`/`v_addr`.
- `vsync` input 1 — vertical sync, active-low pulse.
- `mode_req` input 3 — requested pattern mode.
- `data` output 24 — pixel colour {R,G,B}, registered.
- `mode` output 3 — mode currently displayed.
- `frame_tick` output 1 — one-cycle pulse at each frame boundary.
- `frame_cnt` output FCNT_W — frames since reset, wraps.

## Operation
- **Palette `pal[0..7]`:** ff0000, 00ff00, 0000ff, ffff00, ff00ff, 00ffff, ffffff, 000000.
- **Frame boundary:**
  - `vsync` is registered into `vsync_d`.
  - Boundary = `vsync_d`==1 && `vsync`==0 (vsync falling edge).
  - On the boundary: `frame_tick`=1 for that cycle, `frame_cnt` += 1 (mod 2^FCNT_W), and `mode` <= `mode_req`.
- **Mode latching:** `mode_req` is ignored at all other times. A mode never changes mid-frame.
- **Scroll offset `off`** (10-bit):
  - On a boundary where the new mode is 4 and the old mode was 4: `off` <= (`off` + SCROLL_STEP) mod 1024.
  - On a boundary entering mode 4 from any other mode: `off` <= 0.
  - Otherwise `off` holds.
- **Modes** (x = `h_addr`, y = `v_addr`):
  - 0 vertical bars: `pal[(x>>BAR_LOG2)&7]`.
  - 1 horizontal bars: `pal[(y>>BAR_LOG2)&7]`.
  - 2 checkerboard: ffffff if ((x>>CELL_LOG2) ^ (y>>CELL_LOG2)) bit0 == 0, else 000000.
  - 3 gradient: R=x[9:2], G=y[8:1], B=(x[9:2]^y[8:1]).
  - 4 scrolling bars: `pal[(((x+off) mod 1024)>>BAR_LOG2)&7]`.
  - 5–7 reserved: solid 808080.
- **Blanking:** when `valid`==0 the sampled pixel is 000000 regardless of mode.
- **Arithmetic:** all sums are 10-bit and wrap silently. Shifts are logical.

## Timing
- **Reset values** (asynchronous on `reset`==0): `data`=0, `mode`=0, `frame_tick`=0, `frame_cnt`=0, `off`=0, `vsync_d`=1.
- **Release:** the first boundary is the first vsync falling edge after `reset` deasserts.
- **Latency:** `data` at cycle n+1 reflects `h_addr`/`v_addr`/`valid`/`mode` sampled at cycle n. Exactly one cycle, every mode.
- **Boundary cycle:**
  - `data` for that cycle uses the old mode.
  - The new `mode`/`off` apply from the next cycle.
  - `frame_tick` and `frame_cnt` update together.
- **Vsync held low** for many cycles: only one boundary.
- **Reset mid-frame:** all state clears immediately and the output goes black; no partial-frame mode change survives.
- **`mode_req` toggling** between boundaries: only the value present on the boundary cycle is taken.

## Configuration
- **Macro `VGA_PATTERN_SCROLL_EN` defined:** mode 4 scrolls as specified; the `off` register and adder are present.
- **Macro not defined:**
  - `off` is removed (constant 0).
  - Mode 4 renders identically to mode 0.
  - `mode` still reports 4 when selected.

## Test plan
- **Reset:** assert `reset`=0 mid-line → `data`=000000, `mode`=0, `frame_cnt`=0 within the same cycle; release and pulse vsync once → `frame_tick` one cycle, `frame_cnt`=1.
- **Mode 0, defaults:** `valid`=1, h_addr=0/63/64/447/448 → `data` one cycle later = ff0000/ff0000/00ff00/ffffff/000000; `valid`=0 → 000000.
- **Mode switch:** `mode_req`=2 mid-frame → `mode` stays 0 until the vsync falling edge, then 2. At (32,0) → 000000; at (32,32) → ffffff.
- **Scroll:** `mode_req`=4 across three boundaries with SCROLL_STEP=4 → `off`=0, 4, 8. With `off`=8, h_addr=56 → 00ff00. Leave to mode 0 and return → `off` restarts at 0. Without `VGA_PATTERN_SCROLL_EN` → h_addr=56 gives ff0000.
- **Gradient/reserved:** mode 3, (h,v)=(400,200) → data=64_64_00. Mode 6 → 808080.
- **Frame counter wrap:** FCNT_W=4, 16 boundaries → `frame_cnt` returns to 0 with `frame_tick` still pulsing.

Source files
------------

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: raster-position inputs and pixel/frame-status outputs of the pattern source.
`default_nettype none

interface vga_pattern_gen_if #(
  parameter int FCNT_W = 16
);
  logic [9:0]        h_addr;
  logic [9:0]        v_addr;
  logic              valid;
  logic              vsync;
  logic [2:0]        mode_req;
  logic [23:0]       data;
  logic [2:0]        mode;
  logic              frame_tick;
  logic [FCNT_W-1:0] frame_cnt;

  // Raster side: supplies pixel coordinates and collects colour.
  modport master (
    output h_addr, v_addr, valid, vsync, mode_req,
    input  data, mode, frame_tick, frame_cnt
  );

  // Pattern generator side.
  modport slave (
    input  h_addr, v_addr, valid, vsync, mode_req,
    output data, mode, frame_tick, frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: multi-mode VGA test-pattern source with frame-synchronous mode switching.
// Optional per-frame scroll of mode 4 enabled by macro VGA_PATTERN_SCROLL_EN.
`default_nettype none

module vga_pattern_gen #(
  parameter int BAR_LOG2    = 6,
  parameter int CELL_LOG2   = 5,
  parameter int SCROLL_STEP = 4,
  parameter int FCNT_W      = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  vga_pattern_gen_if.slave  bus
);

  logic              vsync_dly_q;
  logic [2:0]        mode_q;
  logic [23:0]       data_q,  data_d;
  logic              tick_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [9:0]        off_w;
  logic              boundary_w;

  assign boundary_w = vsync_dly_q & ~bus.vsync;

  function automatic logic [23:0] pal(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hff0000;
      3'd1:    return 24'h00ff00;
      3'd2:    return 24'h0000ff;
      3'd3:    return 24'hffff00;
      3'd4:    return 24'hff00ff;
      3'd5:    return 24'h00ffff;
      3'd6:    return 24'hffffff;
      default: return 24'h000000;
    endcase
  endfunction

`ifdef VGA_PATTERN_SCROLL_EN
  logic [9:0] off_q, off_d;

  // Consecutive mode-4 frames advance the scroll; entering mode 4 restarts it.
  always_comb begin
    off_d = off_q;
    if (boundary_w && bus.mode_req == 3'd4) begin
      off_d = (mode_q == 3'd4) ? off_q + 10'(SCROLL_STEP) : 10'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) off_q <= 10'd0;
    else        off_q <= off_d;
  end

  assign off_w = off_q;
`else
  assign off_w = 10'd0;
`endif

  always_comb begin
    logic [9:0] sx;
    sx     = bus.h_addr + off_w;
    data_d = 24'h000000;
    if (bus.valid) begin
      case (mode_q)
        3'd0: data_d = pal(3'((bus.h_addr >> BAR_LOG2) & 10'd7));
        3'd1: data_d = pal(3'((bus.v_addr >> BAR_LOG2) & 10'd7));
        3'd2: data_d = (1'(((bus.h_addr ^ bus.v_addr) >> CELL_LOG2) & 10'd1))
                       ? 24'h000000 : 24'hffffff;
        3'd3: data_d = {bus.h_addr[9:2], bus.v_addr[8:1],
                        bus.h_addr[9:2] ^ bus.v_addr[8:1]};
        3'd4: data_d = pal(3'((sx >> BAR_LOG2) & 10'd7));
        default: data_d = 24'h808080;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_dly_q <= 1'b1;
      mode_q      <= 3'd0;
      data_q      <= 24'h000000;
      tick_q      <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      vsync_dly_q <= bus.vsync;
      data_q      <= data_d;
      tick_q      <= boundary_w;
      if (boundary_w) begin
        mode_q <= bus.mode_req;
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.mode       = mode_q;
  assign bus.frame_tick = tick_q;
  assign bus.frame_cnt  = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench comparing vga_pattern_gen against a behavioural pattern model.
`default_nettype none

module tb_vga_pattern_gen;

  localparam int BAR_LOG2    = 6;
  localparam int CELL_LOG2   = 5;
  localparam int SCROLL_STEP = 4;
  localparam int FCNT_W      = 4;
  localparam int BAR         = 1 << BAR_LOG2;
  localparam int CELL        = 1 << CELL_LOG2;

  typedef struct {
    logic [23:0]       data;
    logic [2:0]        mode;
    logic              tick;
    logic [FCNT_W-1:0] fcnt;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t expq[$];

  bit [23:0] PAL [8] = '{24'hff0000, 24'h00ff00, 24'h0000ff, 24'hffff00,
                         24'hff00ff, 24'h00ffff, 24'hffffff, 24'h000000};

  int m_mode;
  int m_off;
  int m_fcnt;
  bit m_vprev;

  vga_pattern_gen_if #(.FCNT_W(FCNT_W)) bus ();

  vga_pattern_gen #(
    .BAR_LOG2    (BAR_LOG2),
    .CELL_LOG2   (CELL_LOG2),
    .SCROLL_STEP (SCROLL_STEP),
    .FCNT_W      (FCNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [23:0] ref_pixel(int x, int y, bit v, int md, int off);
    if (!v) return 24'h000000;
    case (md)
      0: return PAL[(x / BAR) % 8];
      1: return PAL[(y / BAR) % 8];
      2: return (((x / CELL) + (y / CELL)) % 2 == 0) ? 24'hffffff : 24'h000000;
      3: begin
        int r, g;
        r = x / 4;
        g = (y / 2) % 256;
        return {8'(r), 8'(g), 8'(r ^ g)};
      end
      4: return PAL[(((x + off) % 1024) / BAR) % 8];
      default: return 24'h808080;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_off   = 0;
    m_fcnt  = 0;
    m_vprev = 1'b1;
  endtask

  task automatic drive(int x, int y, bit v, bit vs, int mr);
    exp_t e;
    bit   bnd;
    @(negedge clk);
    bus.h_addr   = 10'(x);
    bus.v_addr   = 10'(y);
    bus.valid    = v;
    bus.vsync    = vs;
    bus.mode_req = 3'(mr);
    e.data = ref_pixel(x, y, v, m_mode, m_off);
    bnd    = m_vprev && !vs;
    m_vprev = vs;
    if (bnd) begin
`ifdef VGA_PATTERN_SCROLL_EN
      if (mr == 4) m_off = (m_mode == 4) ? (m_off + SCROLL_STEP) % 1024 : 0;
`endif
      m_mode = mr;
      m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
    end
    e.mode = 3'(m_mode);
    e.tick = bnd;
    e.fcnt = FCNT_W'(m_fcnt);
    expq.push_back(e);
  endtask

  // One frame boundary: vsync low for one cycle then high again.
  task automatic frame(int mr);
    drive(0, 0, 1'b0, 1'b0, mr);
    drive(0, 0, 1'b0, 1'b1, mr);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    bus.vsync = 1'b1;
    bus.valid = 1'b0;
    expq.delete();
    model_reset();
    #1;
    tests++;
    if (bus.data !== 24'h0 || bus.mode !== 3'd0 || bus.frame_cnt !== '0 || bus.frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset: data=%h mode=%0d fcnt=%0d tick=%b, required all zero",
               bus.data, bus.mode, bus.frame_cnt, bus.frame_tick);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (bus.data !== e.data || bus.mode !== e.mode ||
            bus.frame_tick !== e.tick || bus.frame_cnt !== e.fcnt) begin
          fails++;
          $display("FAIL pixel t=%0t: got data=%h mode=%0d tick=%b fcnt=%0d, expected data=%h mode=%0d tick=%b fcnt=%0d",
                   $time, bus.data, bus.mode, bus.frame_tick, bus.frame_cnt,
                   e.data, e.mode, e.tick, e.fcnt);
        end
      end
    end
  end

  initial begin
    int vcnt;
    tests        = 0;
    fails        = 0;
    reset        = 1'b0;
    bus.h_addr   = '0;
    bus.v_addr   = '0;
    bus.valid    = 1'b0;
    bus.vsync    = 1'b1;
    bus.mode_req = '0;
    model_reset();

    apply_reset();
    frame(0);

    foreach (PAL[i]) drive(i * BAR, 5, 1'b1, 1'b1, 0);
    drive(0,   0, 1'b1, 1'b1, 0);
    drive(63,  0, 1'b1, 1'b1, 0);
    drive(64,  0, 1'b1, 1'b1, 0);
    drive(447, 0, 1'b1, 1'b1, 0);
    drive(448, 0, 1'b1, 1'b1, 0);
    drive(64,  0, 1'b0, 1'b1, 0);

    // Requested mode must not take effect until the vsync falling edge.
    for (int i = 0; i < 4; i++) drive(100 + i, 3, 1'b1, 1'b1, 2);
    drive(0, 0, 1'b1, 1'b0, 2);
    for (int i = 0; i < 6; i++) drive(0, 0, 1'b1, 1'b0, i % 8);
    drive(32, 0,  1'b1, 1'b1, 5);
    drive(32, 32, 1'b1, 1'b1, 1);

    frame(4);
    drive(56, 0, 1'b1, 1'b1, 4);
    frame(4);
    drive(56, 0, 1'b1, 1'b1, 4);
    frame(4);
    drive(56, 0, 1'b1, 1'b1, 4);
    drive(1020, 0, 1'b1, 1'b1, 4);
    frame(0);
    frame(4);
    drive(56, 0, 1'b1, 1'b1, 4);

    frame(3);
    drive(400, 200, 1'b1, 1'b1, 0);
    drive(1023, 511, 1'b1, 1'b1, 0);
    frame(6);
    drive(10, 10, 1'b1, 1'b1, 0);
    frame(1);
    drive(0, 64, 1'b1, 1'b1, 0);

    for (int i = 0; i < 18; i++) frame(i % 8);

    // Random raster traffic with irregular frames and a mid-frame reset.
    vcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      bit vs;
      int mr;
      if (i == 1500) apply_reset();
      vcnt = (vcnt + 1) % 40;
      vs   = !(vcnt < int'($urandom_range(0, 3)) || ($urandom_range(0, 99) == 0));
      mr   = ($urandom_range(0, 1) == 1) ? 4 : int'($urandom_range(0, 7));
      drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            1'($urandom_range(0, 3) != 0), vs, mr);
    end

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
